// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note table, voice state type and popcount helper for poly_piano
package piano_pkg;

    // Half-period counts at octave 0 for a 10 MHz clock, C through B.
    localparam logic [15:0] NOTE_DIV [0:11] = '{
        16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635,
        16'd27027, 16'd25511, 16'd24079, 16'd22727, 16'd21452, 16'd20248
    };

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } voice_state_e;

    function automatic logic [3:0] popcount(input logic [7:0] bits);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/voice_osc.sv
// rtl/voice_osc.sv - per-voice square-wave oscillator with half-period counter and tone register
module voice_osc #(
    parameter int WIDTH_COUNTER = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     active_i,
    input  logic [WIDTH_COUNTER-1:0] half_i,
    output logic                     tone_o
);

    logic [WIDTH_COUNTER-1:0] cnt_q, cnt_d;
    logic                     tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (start_i || !active_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == half_i - WIDTH_COUNTER'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else if (cnt_q >= half_i) begin
            // half shrank under us: restart the period without a toggle
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH_COUNTER'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/poly_piano.sv
// rtl/poly_piano.sv - polyphonic key-to-voice allocator with tone mixer and first-order PDM output
module poly_piano
    import piano_pkg::*;
#(
    parameter int NUM_KEYS      = 12,
    parameter int NUM_VOICES    = 4,
    parameter int WIDTH_COUNTER = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ena,
    input  logic [NUM_KEYS-1:0]                 keys_i,
    input  logic [2:0]                          octave_i,
    output logic [NUM_VOICES-1:0]               voice_active_o,
    output logic [$clog2(NUM_VOICES+1)-1:0]     mix_o,
    output logic                                pdm_o,
    output logic                                starved_o
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int MW = $clog2(NUM_VOICES + 1);
    localparam int AW = MW + 1;

    logic [NUM_KEYS-1:0]   sync1_q, keys_s_q;
    voice_state_e          state_q [NUM_VOICES];
    voice_state_e          state_d [NUM_VOICES];
    logic [KW-1:0]         key_q   [NUM_VOICES];
    logic [KW-1:0]         key_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] start, active_next, tone_w;
    logic [NUM_KEYS-1:0]   owned, pending;
    logic [KW-1:0]         alloc_key;
    logic                  have_key, any_idle, granted, starved_q, starved_d;
    logic [MW-1:0]         mix_q, mix_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic                  pdm_raw;

    function automatic logic [WIDTH_COUNTER-1:0] calc_half(input logic [KW-1:0] key,
                                                          input logic [2:0]    oct_base);
        int unsigned              oct;
        logic [15:0]              div;
        logic [WIDTH_COUNTER-1:0] half;
        oct = int'(oct_base) + int'(key) / 12;
        if (oct > 7) oct = 7;
        div  = NOTE_DIV[int'(key) % 12] >> oct;
        half = WIDTH_COUNTER'(div);
        if (half == '0) half = WIDTH_COUNTER'(1);
        return half;
    endfunction

    // Voices freed this cycle are still ACTIVE in state_q, so they only become allocatable next cycle.
    always_comb begin
        owned    = '0;
        any_idle = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (state_q[v] == ACTIVE) owned[key_q[v]] = 1'b1;
            else                      any_idle = 1'b1;
        end
        pending   = keys_s_q & ~owned;
        have_key  = 1'b0;
        alloc_key = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (pending[k] && !have_key) begin
                have_key  = 1'b1;
                alloc_key = KW'(k);
            end
        end
        granted = 1'b0;
        start   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            key_d[v]   = key_q[v];
            if (state_q[v] == ACTIVE && !keys_s_q[key_q[v]]) begin
                state_d[v] = IDLE;
            end else if (state_q[v] == IDLE && have_key && !granted) begin
                state_d[v] = ACTIVE;
                key_d[v]   = alloc_key;
                start[v]   = 1'b1;
                granted    = 1'b1;
            end
        end
        starved_d = (|pending) && !any_idle;
        mix_d     = MW'(popcount(8'(tone_w)));
        pdm_raw   = (acc_q >= AW'(NUM_VOICES));
        acc_d     = acc_q + AW'(mix_q) - (pdm_raw ? AW'(NUM_VOICES) : AW'(0));
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign voice_active_o[v] = (state_q[v] == ACTIVE);
        assign active_next[v]    = (state_d[v] == ACTIVE);

        voice_osc #(
            .WIDTH_COUNTER(WIDTH_COUNTER)
        ) u_osc (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (start[v]),
            .active_i (active_next[v]),
            .half_i   (calc_half(key_q[v], octave_i)),
            .tone_o   (tone_w[v])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            keys_s_q  <= '0;
            starved_q <= 1'b0;
            mix_q     <= '0;
            acc_q     <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= IDLE;
                key_q[v]   <= '0;
            end
        end else begin
            sync1_q   <= keys_i;
            keys_s_q  <= sync1_q;
            starved_q <= starved_d;
            mix_q     <= mix_d;
            acc_q     <= acc_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= state_d[v];
                key_q[v]   <= key_d[v];
            end
        end
    end

    assign mix_o     = mix_q;
    assign starved_o = starved_q;
    assign pdm_o     = pdm_raw & ena;

endmodule

// File: tb/tb_poly_piano.sv
// tb/tb_poly_piano.sv - randomized self-checking bench for poly_piano against a cycle-level note model
module tb_poly_piano;

    localparam int NK = 24;
    localparam int NV = 4;
    localparam int WC = 16;
    localparam int MW = $clog2(NV + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic [NK-1:0] keys_i = '0;
    logic [2:0]    octave_i = 3'd0;
    logic [NV-1:0] voice_active_o;
    logic [MW-1:0] mix_o;
    logic          pdm_o;
    logic          starved_o;

    poly_piano #(
        .NUM_KEYS      (NK),
        .NUM_VOICES    (NV),
        .WIDTH_COUNTER (WC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .keys_i         (keys_i),
        .octave_i       (octave_i),
        .voice_active_o (voice_active_o),
        .mix_o          (mix_o),
        .pdm_o          (pdm_o),
        .starved_o      (starved_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int div_tab [12] = '{38223, 36077, 34052, 32141, 30337, 28635,
                         27027, 25511, 24079, 22727, 21452, 20248};

    logic [NK-1:0] m_s1, m_s2;
    bit            m_act [NV];
    int            m_key [NV];
    longint        m_t0  [NV];
    int            m_mix, m_acc;
    bit            m_starved;
    longint        cyc = 0;
    bit            chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int half_of(int k, int ob);
        int o, h;
        o = ob + k / 12;
        if (o > 7) o = 7;
        h = (div_tab[k % 12] >> o) % (1 << WC);
        if (h < 1) h = 1;
        return h;
    endfunction

    // Level of voice v after the most recent edge: a square wave timed from its allocation edge.
    function automatic int tone_of(int v);
        if (!m_act[v]) return 0;
        return int'(((cyc - m_t0[v]) / longint'(half_of(m_key[v], int'(octave_i)))) % 2);
    endfunction

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_mix = 0;
        m_acc = 0;
        m_starved = 1'b0;
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 1'b0;
            m_key[v] = 0;
            m_t0[v]  = 0;
        end
    endtask

    task automatic step();
        int            tones, k_sel;
        logic [NK-1:0] owned, pend;
        bit            idle, granted, pdm_raw;
        bit            prev_act [NV];
        logic [NV-1:0] exp_va;
        @(posedge clk);
        tones = 0;
        owned = '0;
        idle  = 1'b0;
        for (int v = 0; v < NV; v++) begin
            tones += tone_of(v);
            prev_act[v] = m_act[v];
            if (m_act[v]) owned[m_key[v]] = 1'b1;
            else          idle = 1'b1;
        end
        pend      = m_s2 & ~owned;
        pdm_raw   = (m_acc >= NV);
        m_acc     = m_acc + m_mix - (pdm_raw ? NV : 0);
        m_mix     = tones;
        m_starved = (pend != '0) && !idle;
        k_sel = -1;
        for (int k = NK - 1; k >= 0; k--) if (pend[k]) k_sel = k;
        for (int v = 0; v < NV; v++) if (m_act[v] && !m_s2[m_key[v]]) m_act[v] = 1'b0;
        granted = 1'b0;
        for (int v = 0; v < NV; v++) begin
            if (!granted && k_sel >= 0 && !prev_act[v]) begin
                m_act[v] = 1'b1;
                m_key[v] = k_sel;
                m_t0[v]  = cyc + 1;
                granted  = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = keys_i;
        cyc++;
        #1;
        if (chk_en) begin
            for (int v = 0; v < NV; v++) exp_va[v] = m_act[v];
            check_eq("voice_active", 64'(voice_active_o), 64'(exp_va));
            check_eq("mix", 64'(mix_o), 64'(m_mix));
            check_eq("starved", 64'(starved_o), 64'(m_starved));
            check_eq("pdm", 64'(pdm_o), 64'((m_acc >= NV) && ena));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_mix_change(output int n);
        logic [MW-1:0] prev;
        prev = mix_o;
        n = 0;
        do begin
            step();
            n++;
        end while (mix_o == prev && n < 3000);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_voice_active", 64'(voice_active_o), 64'd0);
        check_eq("reset_mix", 64'(mix_o), 64'd0);
        check_eq("reset_pdm", 64'(pdm_o), 64'd0);
        check_eq("reset_starved", 64'(starved_o), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single key 9 at octave 0: long half period of 22727 cycles.
        keys_i[9] = 1'b1;
        steps(3);
        check_eq("single_alloc_edge3", 64'(voice_active_o), 64'b0001);
        n = 3;
        while (mix_o == '0 && n < 23000) begin
            step();
            n++;
        end
        check_eq("single_first_mix_edge", 64'(n), 64'(3 + 22727 + 1));
        keys_i = '0;
        steps(8);

        // Chord allocated in ascending key order on consecutive edges.
        octave_i = 3'd7;
        keys_i[0] = 1'b1;
        keys_i[4] = 1'b1;
        keys_i[7] = 1'b1;
        steps(3);
        check_eq("order_edge3", 64'(voice_active_o), 64'b0001);
        step();
        check_eq("order_edge4", 64'(voice_active_o), 64'b0011);
        step();
        check_eq("order_edge5", 64'(voice_active_o), 64'b0111);
        steps(600);
        keys_i = '0;
        steps(8);

        // Starvation: five keys on four voices, then free one.
        octave_i = 3'd6;
        keys_i = '0;
        keys_i[1] = 1'b1;
        keys_i[2] = 1'b1;
        keys_i[3] = 1'b1;
        keys_i[5] = 1'b1;
        keys_i[6] = 1'b1;
        steps(7);
        check_eq("starve_full", 64'(voice_active_o), 64'b1111);
        check_eq("starve_set", 64'(starved_o), 64'd1);
        keys_i[1] = 1'b0;
        steps(3);
        check_eq("starve_release_va", 64'(voice_active_o), 64'b1110);
        check_eq("starve_still", 64'(starved_o), 64'd1);
        step();
        check_eq("starve_realloc_va", 64'(voice_active_o), 64'b1111);
        check_eq("starve_clear", 64'(starved_o), 64'd0);
        steps(300);
        keys_i = '0;
        steps(8);

        // Key 21 at octave 6 saturates at octave 7: half = 177.
        keys_i[21] = 1'b1;
        n = 0;
        while (mix_o == '0 && n < 400) begin
            step();
            n++;
        end
        check_eq("oct_sat_first_mix_edge", 64'(n), 64'(3 + 177 + 1));
        keys_i = '0;
        steps(8);

        // Randomized churn with a fixed octave per phase.
        for (int ph = 0; ph < 8; ph++) begin
            octave_i = 3'($urandom_range(5, 7));
            ena = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NK; k++) keys_i[k] = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 600; i++) begin
                step();
                if ($urandom_range(0, 39) == 0) begin
                    n = $urandom_range(0, NK - 1);
                    keys_i[n] = ~keys_i[n];
                end
            end
            keys_i = '0;
            steps(8);
        end
        ena = 1'b1;

        // Octave change on a held note re-times the tone without losing the voice.
        chk_en = 1'b0;
        octave_i = 3'd7;
        keys_i[9] = 1'b1;
        steps(300);
        octave_i = 3'd5;
        wait_mix_change(n);
        wait_mix_change(n);
        check_eq("octave_down_period", 64'(n), 64'd710);
        check_eq("octave_down_va", 64'(voice_active_o), 64'b0001);
        steps(400);
        octave_i = 3'd7;
        wait_mix_change(n);
        wait_mix_change(n);
        check_eq("octave_up_period", 64'(n), 64'd177);
        check_eq("octave_up_va", 64'(voice_active_o), 64'b0001);

        // Reset mid-chord with three keys held.
        keys_i = '0;
        keys_i[2] = 1'b1;
        keys_i[5] = 1'b1;
        keys_i[8] = 1'b1;
        steps(12);
        check_eq("chord_before_reset", 64'(voice_active_o != '0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_voice_active", 64'(voice_active_o), 64'd0);
        check_eq("midreset_mix", 64'(mix_o), 64'd0);
        check_eq("midreset_pdm", 64'(pdm_o), 64'd0);
        check_eq("midreset_starved", 64'(starved_o), 64'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        steps(3);
        check_eq("postreset_edge3", 64'(voice_active_o), 64'b0001);
        step();
        check_eq("postreset_edge4", 64'(voice_active_o), 64'b0011);
        step();
        check_eq("postreset_edge5", 64'(voice_active_o), 64'b0111);
        ena = 1'b0;
        steps(500);
        ena = 1'b1;
        steps(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
